corr_frame_gen: RTL
===================

// Module: corr_frame_gen
// PURPOSE
//  Snapshot framer and conjugate-product generator that feeds the correlation accumulator.
//  - Takes paired complex samples x (ch A) and y (ch B).
//  - Emits Re{x*conj(y)} = xI*yI + xQ*yQ as a sign-extended 31-bit stream with valid/last framing.
//  - Inserts a guard gap after each last, so the accumulator's clear cycle never coincides with a new sample.
//  - Sits between the ADC sample aligner and the accumulator, one instance per antenna pair.
// PARAMETERS
//  DW       12  signed sample width per I/Q component
//  LEN_W    16  snapshot-length counter width
//  GAP_CYC   1  guard cycles after each last input sample (>=1)
// PORTS
//  i_clk        in   1      clock
//  i_resetn     in   1      async active-low reset
//  i_start      in   1      pulse: arm a snapshot run (ignored while o_busy)
//  i_cont       in   1      1 = re-arm automatically after each snapshot; sampled at each gap end
//  i_snap_len   in   LEN_W  samples per snapshot; latched on accepted i_start
//  i_valid      in   1      sample strobe
//  i_xi,i_xq    in   DW     ch A I/Q, signed
//  i_yi,i_yq    in   DW     ch B I/Q, signed
//  o_data       out  31     Re{x*conj(y)}, 2*DW+1 bits sign-extended to 31
//  o_valid      out  1      o_data valid
//  o_last       out  1      qualifies final product of a snapshot (only with o_valid)
//  o_busy       out  1      state != IDLE or pipeline non-empty
//  o_done       out  1      1-cycle pulse on return to IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counter 0, pipeline valid/last cleared. Reset mid-run abandons the frame with no o_last.
//  - FSM IDLE->RUN on i_start with i_snap_len!=0. Latch len, count=0.
//    - i_start with len==0 is ignored; stays IDLE, no o_done.
//  - RUN: each i_valid sample is accepted, count++.
//    - Sample where count==len-1 is tagged last; go to GAP with gap counter = GAP_CYC.
//  - GAP: i_valid samples are dropped (not accepted, not counted). Gap counter decrements each cycle.
//    - At zero: if i_cont, go to RUN (count=0, same latched len).
//    - Otherwise go to IDLE.
//  - o_done pulses the cycle after the pipeline drains in IDLE. That is the cycle after o_last when the gap is already over.
//  - Pipeline latency is 2 cycles, accepted sample to o_valid:
//    - st1 registers xI*yI and xQ*yQ (2*DW each).
//    - st2 registers the sum (2*DW+1) and sign-extends it to 31.
//    - valid/last travel alongside the data. No backpressure; the downstream always accepts.
//  - Arithmetic is full precision, with no rounding or saturation.
//    - Worst case (-2^(DW-1))^2*2 = 2^(2DW-1) fits in signed 2*DW+1.
//  - o_data holds its value when o_valid=0.
//  - i_start while busy is ignored.
//  - i_start and i_valid in the same IDLE cycle: the sample is not accepted; the first sample is the next i_valid in RUN.
//  - len==1: every accepted sample carries last.
//  - Counter wrap cannot occur: count < len <= 2^LEN_W-1.
// CONFIGURATION
//  CORR_FRAME_STATUS_EN defined adds three extra outputs:
//    - o_frame_cnt [15:0]: +1 per o_last, wraps at 2^16.
//    - o_drop_cnt [15:0]: +1 per i_valid dropped in GAP or IDLE, saturates at 0xFFFF.
//    - Both counters clear only on reset.
//  Undefined: these ports are absent and no status logic is built.
// STRUCTURE
//  - Shared package corr_pkg holds:
//    - CORR_OUT_W=31
//    - state typedef {IDLE,RUN,GAP}
//    - default DW/LEN_W
//  - Sub-module corr_cmult implements the 2-stage conjugate-product real-part pipeline.
//    - Its inputs are the 4 samples plus vld/last.
//    - Its outputs are data/vld/last.
//  - Top level holds the FSM, counters and optional status.
// TESTING
//  1. Reset, len=4, start, 4 valid samples x=(3,-2), y=(5,7).
//     -> 4x o_data=1 (15-14), o_valid at cycles 2..5 after the first sample, o_last on the 4th, o_done next cycle.
//  2. DW=12, x=y=(-2048,-2048).
//     -> o_data=8388608 (2^23), sign-extended correctly. x=(-2048,0), y=(2047,0) -> -4192256.
//  3. i_cont=1, len=3, i_valid held high for 10 cycles.
//     -> frames of 3 with one dropped sample each gap, o_last every 4th accepted slot, no o_done.
//     -> with the status macro, drop_cnt=2 and frame_cnt=2 after 10 cycles.
//  4. len=0 start -> stays IDLE, o_busy=0, no output.
//     - Then i_start during RUN with len=5 in progress -> ignored; the frame still ends at the 5th sample.
//  5. Assert i_resetn=0 after 2 of 4 samples.
//     -> outputs 0 immediately, no o_last.
//     -> a new start after release produces a clean 4-sample frame.

Source files
------------

// File: rtl/corr_pkg.sv
// Shared definitions for the correlation framer: output width, FSM states and
// default geometry used by corr_frame_gen and corr_cmult.
package corr_pkg;

  localparam int CORR_OUT_W   = 31;
  localparam int CORR_DW      = 12;
  localparam int CORR_LEN_W   = 16;
  localparam int CORR_GAP_CYC = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } corr_state_t;

  // Width of a down-counter that must hold the value cyc (never below 1 bit).
  function automatic int corr_cnt_w(input int cyc);
    return (cyc < 2) ? 1 : $clog2(cyc + 1);
  endfunction

endpackage

// File: rtl/corr_cmult.sv
// Two-stage Re{x*conj(y)} pipeline: stage 1 registers xI*yI and xQ*yQ, stage 2
// registers their sum sign-extended to CORR_OUT_W. Valid/last ride alongside.
module corr_cmult
  import corr_pkg::*;
#(
  parameter int DW = CORR_DW
) (
  input  logic                  i_clk,
  input  logic                  i_resetn,
  input  logic signed [DW-1:0]  xi_i,
  input  logic signed [DW-1:0]  xq_i,
  input  logic signed [DW-1:0]  yi_i,
  input  logic signed [DW-1:0]  yq_i,
  input  logic                  vld_i,
  input  logic                  last_i,
  output logic [CORR_OUT_W-1:0] data_o,
  output logic                  vld_o,
  output logic                  last_o,
  output logic                  st1_vld_o
);

  localparam int PW  = 2 * DW;
  localparam int SW  = 2 * DW + 1;
  localparam int EXT = CORR_OUT_W - SW;

  logic signed [PW-1:0]  p_ii_d, p_qq_d;
  logic signed [PW-1:0]  p_ii_q, p_qq_q;
  logic                  st1_vld_q, st1_last_q;
  logic [SW-1:0]         sum_d;
  logic [CORR_OUT_W-1:0] data_d, data_q;
  logic                  vld_q, last_q;

  // Operands are widened before multiplying so the full 2*DW product is kept.
  assign p_ii_d = (PW)'(xi_i) * (PW)'(yi_i);
  assign p_qq_d = (PW)'(xq_i) * (PW)'(yq_i);
  assign sum_d  = {p_ii_q[PW-1], p_ii_q} + {p_qq_q[PW-1], p_qq_q};
  assign data_d = {{EXT{sum_d[SW-1]}}, sum_d};

  // NOTE: sequential state uses <= so every register samples pre-edge values;
  // the datapath registers are reset too because the outputs must read 0 in reset.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      p_ii_q     <= '0;
      p_qq_q     <= '0;
      st1_vld_q  <= 1'b0;
      st1_last_q <= 1'b0;
      data_q     <= '0;
      vld_q      <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      st1_vld_q  <= vld_i;
      st1_last_q <= vld_i & last_i;
      vld_q      <= st1_vld_q;
      last_q     <= st1_vld_q & st1_last_q;
      if (vld_i) begin
        p_ii_q <= p_ii_d;
        p_qq_q <= p_qq_d;
      end
      // Output data only moves with a valid product and holds otherwise.
      if (st1_vld_q) begin
        data_q <= data_d;
      end
    end
  end

  assign data_o    = data_q;
  assign vld_o     = vld_q;
  assign last_o    = last_q;
  assign st1_vld_o = st1_vld_q;

endmodule

// File: rtl/corr_frame_gen.sv
// Snapshot framer feeding the correlation accumulator: frames paired samples into
// snapshots with a guard gap after each last. Optional status counters are built
// when CORR_FRAME_STATUS_EN is defined.
module corr_frame_gen
  import corr_pkg::*;
#(
  parameter int DW      = CORR_DW,
  parameter int LEN_W   = CORR_LEN_W,
  parameter int GAP_CYC = CORR_GAP_CYC
) (
  input  logic                  i_clk,
  input  logic                  i_resetn,
  input  logic                  i_start,
  input  logic                  i_cont,
  input  logic [LEN_W-1:0]      i_snap_len,
  input  logic                  i_valid,
  input  logic signed [DW-1:0]  i_xi,
  input  logic signed [DW-1:0]  i_xq,
  input  logic signed [DW-1:0]  i_yi,
  input  logic signed [DW-1:0]  i_yq,
  output logic [CORR_OUT_W-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_last,
  output logic                  o_busy,
  output logic                  o_done
`ifdef CORR_FRAME_STATUS_EN
  ,
  output logic [15:0]           o_frame_cnt,
  output logic [15:0]           o_drop_cnt
`endif
);

  localparam int GAP_W = corr_cnt_w(GAP_CYC);

  corr_state_t      state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             done_q, done_d;
  logic             st1_vld;
  logic             busy, busy_next;
  logic             start_ok, accept, is_last;

  assign busy     = (state_q != IDLE) | st1_vld | o_valid;
  assign start_ok = i_start & ~busy & (i_snap_len != '0);
  assign accept   = (state_q == RUN) & i_valid;
  assign is_last  = accept & (cnt_q == (len_q - LEN_W'(1)));

  // NOTE: every always_comb output gets its default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = RUN;
          len_d   = i_snap_len;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (is_last) begin
          state_d = GAP;
          gap_d   = GAP_W'(GAP_CYC);
          cnt_d   = '0;
        end else if (accept) begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      GAP: begin
        gap_d = gap_q - GAP_W'(1);
        // Continuous mode is decided on the final gap cycle only.
        if (gap_q == GAP_W'(1)) begin
          state_d = i_cont ? RUN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Done fires on the edge where the framer and its pipeline both go quiet.
  assign busy_next = (state_d != IDLE) | accept | st1_vld;
  assign done_d    = busy & ~busy_next;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
    end
  end

  corr_cmult #(
    .DW(DW)
  ) u_cmult (
    .i_clk     (i_clk),
    .i_resetn  (i_resetn),
    .xi_i      (i_xi),
    .xq_i      (i_xq),
    .yi_i      (i_yi),
    .yq_i      (i_yq),
    .vld_i     (accept),
    .last_i    (is_last),
    .data_o    (o_data),
    .vld_o     (o_valid),
    .last_o    (o_last),
    .st1_vld_o (st1_vld)
  );

  assign o_busy = busy;
  assign o_done = done_q;

`ifdef CORR_FRAME_STATUS_EN
  logic [15:0] frame_cnt_q, drop_cnt_q;
  logic        drop;

  // Anything offered outside RUN is discarded and counted.
  assign drop = i_valid & (state_q != RUN);

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (o_valid & o_last) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if (drop && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  assign o_frame_cnt = frame_cnt_q;
  assign o_drop_cnt  = drop_cnt_q;
`endif

endmodule
